fb_loop_sequencer: RTL and testbench

- Sequences the gyro closed-loop feedback step generator through a lock-acquisition flow: off, open-loop constant step, coarse-gain closed loop, gain ramp, lock.
- Drives the step generator's fb_ON mode, gain_sel shift index and const_step.
- Monitors the demodulated error on each loop trigger.
- Declares lock, and faults out if the error runs away while locked.

---
 rtl/fb_loop_sequencer.sv | 129 ++++++++++++
 tb/tb_fb_loop_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fb_loop_sequencer.sv
// fb_loop_sequencer: lock-acquisition sequencer for the gyro closed-loop feedback step generator
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_start               level enable, low forces IDLE
//   i_trig                one-cycle loop-update strobe
//   i_err                 signed demodulated error
//   i_const_step          open-loop step, latched on CONST entry
//   i_const_cnt           triggers spent in CONST (0 skips CONST)
//   i_gain_start/final    coarse/fine shift index
//   i_settle_thr/cnt      settle magnitude threshold and consecutive good triggers per gain step
//   i_fault_thr/cnt       fault magnitude threshold and consecutive bad triggers (0 disables)
//   o_fb_ON               0 off, 1 closed loop, 2 constant step
//   o_gain_sel            shift index
//   o_const_step          latched constant step
//   o_state               0 IDLE, 1 CONST, 2 ACQ, 3 LOCK, 4 FAULT
//   o_locked, o_fault     LOCK / FAULT flags
module fb_loop_sequencer #(
   parameter int ERR_W   = 32,
   parameter int GOOD_W  = 8,
   parameter int CONST_W = 16
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_start,
   input  logic                    i_trig,
   input  logic signed [ERR_W-1:0] i_err,
   input  logic signed [ERR_W-1:0] i_const_step,
   input  logic [CONST_W-1:0]      i_const_cnt,
   input  logic [3:0]              i_gain_start,
   input  logic [3:0]              i_gain_final,
   input  logic [ERR_W-1:0]        i_settle_thr,
   input  logic [GOOD_W-1:0]       i_settle_cnt,
   input  logic [ERR_W-1:0]        i_fault_thr,
   input  logic [GOOD_W-1:0]       i_fault_cnt,
   output logic [31:0]             o_fb_ON,
   output logic [3:0]              o_gain_sel,
   output logic signed [ERR_W-1:0] o_const_step,
   output logic [2:0]              o_state,
   output logic                    o_locked,
   output logic                    o_fault
);
   typedef enum logic [2:0] {IDLE = 3'd0, CONST = 3'd1, ACQ = 3'd2, LOCK = 3'd3, FAULT = 3'd4} state_t;
   localparam logic [ERR_W-1:0] MIN_NEG = {1'b1, {(ERR_W-1){1'b0}}};
   state_t state;
   logic [CONST_W-1:0] const_cnt, const_nxt;
   logic [GOOD_W-1:0] good_cnt, bad_cnt, good_nxt, bad_nxt, settle;
   logic [ERR_W-1:0] mag;
   logic good, bad;
   assign o_state = state;
   // the most negative error has no positive twin, so it saturates to the largest positive magnitude
   always_comb begin
      mag = i_err == MIN_NEG ? ~MIN_NEG : i_err[ERR_W-1] ? -i_err : i_err;
      good = mag < i_settle_thr;
      bad = mag > i_fault_thr;
      const_nxt = &const_cnt ? const_cnt : const_cnt + 1'b1;
      good_nxt = !good ? '0 : &good_cnt ? good_cnt : good_cnt + 1'b1;
      bad_nxt = !bad ? '0 : &bad_cnt ? bad_cnt : bad_cnt + 1'b1;
      settle = i_settle_cnt == '0 ? GOOD_W'(1) : i_settle_cnt;
   end
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= IDLE;
         const_cnt <= '0;
         good_cnt <= '0;
         bad_cnt <= '0;
         o_fb_ON <= '0;
         o_gain_sel <= 4'd5;
         o_const_step <= '0;
         o_locked <= 1'b0;
         o_fault <= 1'b0;
      end else if (!i_start) begin
         state <= IDLE;
         const_cnt <= '0;
         good_cnt <= '0;
         bad_cnt <= '0;
         o_fb_ON <= '0;
         o_gain_sel <= i_gain_start;
         o_locked <= 1'b0;
         o_fault <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               o_gain_sel <= i_gain_start;
               if (i_const_cnt != '0) begin
                  state <= CONST;
                  o_fb_ON <= 32'd2;
                  o_const_step <= i_const_step;
               end else begin
                  state <= ACQ;
                  o_fb_ON <= 32'd1;
               end
            end
            CONST: begin
               if (i_trig) begin
                  if (const_nxt >= i_const_cnt) begin
                     state <= ACQ;
                     o_fb_ON <= 32'd1;
                     const_cnt <= '0;
                  end else const_cnt <= const_nxt;
               end
            end
            ACQ: begin
               if (i_trig) begin
                  if (good_nxt >= settle) begin
                     good_cnt <= '0;
                     if (o_gain_sel < i_gain_final) o_gain_sel <= o_gain_sel + 4'd1;
                     else begin
                        state <= LOCK;
                        o_locked <= 1'b1;
                     end
                  end else good_cnt <= good_nxt;
               end
            end
            LOCK: begin
               if (i_trig) begin
                  if (i_fault_cnt != '0 && bad_nxt >= i_fault_cnt) begin
                     state <= FAULT;
                     o_fb_ON <= '0;
                     o_locked <= 1'b0;
                     o_fault <= 1'b1;
                     bad_cnt <= '0;
                  end else bad_cnt <= bad_nxt;
               end
            end
            FAULT: ;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fb_loop_sequencer.sv
// tb_fb_loop_sequencer: directed self-checking bench for fb_loop_sequencer
module tb_fb_loop_sequencer;
   logic clk = 1'b0;
   logic rst_n;
   logic start, trig;
   logic signed [31:0] err, const_step;
   logic [15:0] const_cnt;
   logic [3:0] gain_start, gain_final;
   logic [31:0] settle_thr, fault_thr;
   logic [7:0] settle_cnt, fault_cnt;
   logic [31:0] fb_on;
   logic [3:0] gain_sel;
   logic signed [31:0] const_step_o;
   logic [2:0] state;
   logic locked, fault;
   int passed = 0;
   int total = 0;

   fb_loop_sequencer dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_trig(trig), .i_err(err),
      .i_const_step(const_step), .i_const_cnt(const_cnt), .i_gain_start(gain_start),
      .i_gain_final(gain_final), .i_settle_thr(settle_thr), .i_settle_cnt(settle_cnt),
      .i_fault_thr(fault_thr), .i_fault_cnt(fault_cnt), .o_fb_ON(fb_on), .o_gain_sel(gain_sel),
      .o_const_step(const_step_o), .o_state(state), .o_locked(locked), .o_fault(fault)
   );

   always #5 clk = ~clk;

   task automatic pulse();
      @(negedge clk);
      trig = 1'b1;
      @(negedge clk);
      trig = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      total++;
      if ({fb_on, gain_sel, const_step_o, state, locked, fault} !== {32'd0, 4'd5, 32'd0, 3'd0, 1'b0, 1'b0})
         $display("FAIL reset_values got fb=%0d gain=%0d cs=%0d st=%0d lk=%b ft=%b want 0 5 0 0 0 0",
                  fb_on, gain_sel, const_step_o, state, locked, fault);
      else passed++;
      rst_n = 1'b1;
      @(negedge clk);
      total++;
      if ({state, gain_sel} !== {3'd0, 4'd2}) $display("FAIL idle_gain_track got st=%0d gain=%0d want 0 2", state, gain_sel);
      else passed++;
   endtask

   task automatic test_const();
      const_cnt = 16'd3;
      const_step = -32'sd100;
      err = 32'sd100;
      start = 1'b1;
      @(negedge clk);
      total++;
      if ({state, fb_on, const_step_o} !== {3'd1, 32'd2, 32'hFFFF_FF9C})
         $display("FAIL const_entry got st=%0d fb=%0d cs=%0d want 1 2 -100", state, fb_on, const_step_o);
      else passed++;
      const_step = 32'sd55;
      for (int k = 1; k <= 5; k++) begin
         pulse();
         total++;
         if ({state, fb_on, gain_sel} !== {(k < 3 ? 3'd1 : 3'd2), (k < 3 ? 32'd2 : 32'd1), 4'd2})
            $display("FAIL const_trig%0d got st=%0d fb=%0d gain=%0d want %0d %0d 2",
                     k, state, fb_on, gain_sel, k < 3 ? 1 : 2, k < 3 ? 2 : 1);
         else passed++;
      end
      total++;
      if (const_step_o !== 32'hFFFF_FF9C) $display("FAIL const_latched got %0d want -100", const_step_o);
      else passed++;
   endtask

   task automatic test_acq_alternate();
      for (int k = 0; k < 12; k++) begin
         err = k[0] ? 32'sd100 : 32'sd10;
         pulse();
      end
      total++;
      if ({state, gain_sel, locked} !== {3'd2, 4'd2, 1'b0})
         $display("FAIL acq_alternate got st=%0d gain=%0d lk=%b want 2 2 0", state, gain_sel, locked);
      else passed++;
   endtask

   task automatic test_acq_ramp();
      logic [3:0] eg;
      err = 32'sd10;
      for (int k = 1; k <= 16; k++) begin
         pulse();
         eg = k >= 12 ? 4'd5 : 4'(2 + k / 4);
         total++;
         if ({state, gain_sel, locked, fb_on} !== {(k == 16 ? 3'd3 : 3'd2), eg, k == 16, 32'd1})
            $display("FAIL acq_ramp%0d got st=%0d gain=%0d lk=%b fb=%0d want %0d %0d %0d 1",
                     k, state, gain_sel, locked, fb_on, k == 16 ? 3 : 2, eg, k == 16);
         else passed++;
      end
   endtask

   task automatic test_fault();
      fault_thr = 32'h7FFF_FFFF;
      err = 32'sh8000_0000;
      repeat (3) pulse();
      total++;
      if (state !== 3'd3) $display("FAIL mag_saturate got st=%0d want 3", state);
      else passed++;
      fault_thr = 32'd1000;
      pulse(); pulse();
      err = 32'sd5;
      pulse();
      err = 32'sh8000_0000;
      pulse(); pulse();
      total++;
      if (state !== 3'd3) $display("FAIL bad_run_cleared got st=%0d want 3", state);
      else passed++;
      pulse();
      total++;
      if ({state, fb_on, fault, locked, gain_sel} !== {3'd4, 32'd0, 1'b1, 1'b0, 4'd5})
         $display("FAIL fault_entry got st=%0d fb=%0d ft=%b lk=%b gain=%0d want 4 0 1 0 5",
                  state, fb_on, fault, locked, gain_sel);
      else passed++;
      err = 32'sd0;
      pulse(); pulse();
      total++;
      if ({state, fault} !== {3'd4, 1'b1}) $display("FAIL fault_hold got st=%0d ft=%b want 4 1", state, fault);
      else passed++;
      start = 1'b0;
      @(negedge clk);
      total++;
      if ({state, fault, fb_on, gain_sel} !== {3'd0, 1'b0, 32'd0, 4'd2})
         $display("FAIL fault_exit got st=%0d ft=%b fb=%0d gain=%0d want 0 0 0 2", state, fault, fb_on, gain_sel);
      else passed++;
   endtask

   task automatic test_fault_disabled();
      gain_start = 4'd3;
      gain_final = 4'd3;
      settle_cnt = 8'd0;
      const_cnt = 16'd0;
      start = 1'b1;
      @(negedge clk);
      total++;
      if ({state, fb_on, gain_sel} !== {3'd2, 32'd1, 4'd3})
         $display("FAIL skip_const got st=%0d fb=%0d gain=%0d want 2 1 3", state, fb_on, gain_sel);
      else passed++;
      err = 32'sd10;
      pulse();
      total++;
      if ({state, gain_sel, locked} !== {3'd3, 4'd3, 1'b1})
         $display("FAIL start_ge_final got st=%0d gain=%0d lk=%b want 3 3 1", state, gain_sel, locked);
      else passed++;
      fault_cnt = 8'd0;
      err = 32'sh8000_0000;
      repeat (300) pulse();
      total++;
      if ({state, locked, fault} !== {3'd3, 1'b1, 1'b0})
         $display("FAIL fault_disabled got st=%0d lk=%b ft=%b want 3 1 0", state, locked, fault);
      else passed++;
   endtask

   task automatic test_const_abort();
      start = 1'b0;
      gain_start = 4'd2;
      gain_final = 4'd5;
      settle_cnt = 8'd4;
      fault_cnt = 8'd3;
      const_cnt = 16'd3;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      pulse(); pulse();
      start = 1'b0;
      trig = 1'b1;
      @(negedge clk);
      trig = 1'b0;
      total++;
      if ({state, fb_on} !== {3'd0, 32'd0}) $display("FAIL const_abort got st=%0d fb=%0d want 0 0", state, fb_on);
      else passed++;
      start = 1'b1;
      @(negedge clk);
      pulse(); pulse();
      total++;
      if ({state, fb_on} !== {3'd1, 32'd2}) $display("FAIL const_cnt_cleared got st=%0d fb=%0d want 1 2", state, fb_on);
      else passed++;
      pulse();
      total++;
      if (state !== 3'd2) $display("FAIL const_reenter_acq got st=%0d want 2", state);
      else passed++;
   endtask

   task automatic test_async_reset();
      err = 32'sd10;
      repeat (8) pulse();
      total++;
      if ({state, gain_sel} !== {3'd2, 4'd4}) $display("FAIL pre_reset got st=%0d gain=%0d want 2 4", state, gain_sel);
      else passed++;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({fb_on, gain_sel, const_step_o, state, locked, fault} !== {32'd0, 4'd5, 32'd0, 3'd0, 1'b0, 1'b0})
         $display("FAIL async_reset got fb=%0d gain=%0d cs=%0d st=%0d lk=%b ft=%b want 0 5 0 0 0 0",
                  fb_on, gain_sel, const_step_o, state, locked, fault);
      else passed++;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      trig = 1'b0;
      err = '0;
      const_step = '0;
      const_cnt = '0;
      gain_start = 4'd2;
      gain_final = 4'd5;
      settle_thr = 32'd50;
      settle_cnt = 8'd4;
      fault_thr = 32'd1000;
      fault_cnt = 8'd3;
      test_reset();
      test_const();
      test_acq_alternate();
      test_acq_ramp();
      test_fault();
      test_fault_disabled();
      test_const_abort();
      test_async_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
